// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared definitions for the instruction/data memory bus arbiter:
//   requester IDs (the payload carried by the in-order ID FIFO) and the
//   bus transfer size encodings.
package mem_bus_arbiter_pkg;

  // Requester identity; one bit so it can be stored directly in the ID FIFO.
  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// arb_id_fifo
//   In-order FIFO of requester IDs for transactions that are outstanding on
//   the bus. One entry is pushed per accepted request and one popped per bus
//   response, so the head always names the owner of the next response.
//
//   Ports:
//     clk, reset   clock, asynchronous active-high reset (FIFO empties)
//     push, push_id  write push_id at the tail (caller guarantees !full)
//     pop          drop the head entry (caller guarantees !empty)
//     full, empty  occupancy flags from the registered count
//     head         ID at the head of the FIFO
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-like pipelined bus between the instruction-fetch port and
//   the data-access port. Data wins arbitration, but after STARVE_LIMIT
//   consecutive lost grants fetch is forced through. Outstanding requests are
//   tracked in an in-order ID FIFO so each response is routed to its owner.
//
//   Handshake (all three ports): a request (*_req) is held stable with its
//   fields until the same-cycle accept (*_addr_ok); a response (*_data_ok)
//   is a single-cycle strobe with its read data valid in that cycle.
//
//   Ports:
//     clk, reset                       clock, async active-high reset
//     inst_req/addr, inst_addr_ok      fetch request / accept
//     inst_rdata, inst_data_ok         fetch response
//     data_req/wr/size/addr/wdata      data request
//     data_addr_ok                     data accept
//     data_rdata, data_data_ok         data response
//     bus_req/wr/size/addr/wdata       bus request (muxed from the winner)
//     bus_addr_ok                      bus accept
//     bus_rdata, bus_data_ok           bus response, in order
//     proto_err                        sticky: response with nothing pending
//     perfcnt_inst_wait/data_wait      wait-cycle counters
//
//   Build option: define MEM_ARB_PERFCNT_EN to enable the wait-cycle
//   counters; otherwise both read as zero and no counter flops exist.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic [31:0] data_rdata,
  output logic        data_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic [31:0] bus_rdata,
  input  logic        bus_data_ok,
  output logic        proto_err,
  output logic [31:0] perfcnt_inst_wait,
  output logic [31:0] perfcnt_data_wait
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  req_id_e       sel;
  req_id_e       hold_sel_q;
  logic          hold_valid_q;
  logic [SW-1:0] starve_q;
  logic          proto_err_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_head;
  logic          accept;
  logic          pop;

  // A request left waiting on the bus keeps its owner: nothing may preempt
  // it, otherwise the bus would see its request fields change before accept.
  always_comb begin
    sel = REQ_DATA;
    if (hold_valid_q) begin
      sel = hold_sel_q;
    end else if (data_req && inst_req) begin
      sel = (starve_q == STARVE_MAX) ? REQ_INST : REQ_DATA;
    end else if (inst_req) begin
      sel = REQ_INST;
    end
  end

  // Uses the registered count only: a pop in the same cycle does not open a
  // slot, keeping bus_req off the bus_data_ok path.
  assign bus_req   = (inst_req || data_req) && !fifo_full;
  assign bus_wr    = (sel == REQ_INST) ? 1'b0      : data_wr;
  assign bus_size  = (sel == REQ_INST) ? SIZE_WORD : data_size;
  assign bus_addr  = (sel == REQ_INST) ? inst_addr : data_addr;
  assign bus_wdata = (sel == REQ_INST) ? 32'd0     : data_wdata;

  assign accept       = bus_req && bus_addr_ok;
  assign inst_addr_ok = accept && (sel == REQ_INST);
  assign data_addr_ok = accept && (sel == REQ_DATA);

  // Responses with nothing outstanding are dropped and flagged.
  assign pop          = bus_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head == REQ_INST);
  assign data_data_ok = pop && (fifo_head == REQ_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign proto_err    = proto_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= REQ_INST;
      starve_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (bus_req && !bus_addr_ok) begin
        hold_valid_q <= 1'b1;
        hold_sel_q   <= sel;
      end else if (accept) begin
        hold_valid_q <= 1'b0;
      end

      // Counts grants fetch lost to data while both were asking.
      if (!inst_req || inst_addr_ok) begin
        starve_q <= '0;
      end else if (data_addr_ok && data_req && starve_q != STARVE_MAX) begin
        starve_q <= starve_q + SW'(1);
      end

      if (bus_data_ok && fifo_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

`ifdef MEM_ARB_PERFCNT_EN
  logic [31:0] inst_wait_q;
  logic [31:0] data_wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_wait_q <= '0;
      data_wait_q <= '0;
    end else begin
      if (inst_req && !inst_addr_ok) inst_wait_q <= inst_wait_q + 32'd1;
      if (data_req && !data_addr_ok) data_wait_q <= data_wait_q + 32'd1;
    end
  end

  assign perfcnt_inst_wait = inst_wait_q;
  assign perfcnt_data_wait = data_wait_q;
`else
  assign perfcnt_inst_wait = 32'd0;
  assign perfcnt_data_wait = 32'd0;
`endif

endmodule
